// File: rtl/lambert_shade_seq.sv
// Lambert shading sequencer: drives cross_product -> normalize -> dot_product
// over their en/valid handshakes and returns a clamped intensity plus unit normal.
module lambert_shade_seq #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [47:0] edge_a,
    input  logic [47:0] edge_b,
    input  logic [47:0] light,
    output logic        busy,
    output logic        done,
    output logic [15:0] intensity,
    output logic [47:0] unit_normal,
    output logic        degenerate,
    output logic        err,
    output logic        cross_en,
    output logic [47:0] cross_vec_a,
    output logic [47:0] cross_vec_b,
    input  logic [47:0] cross_normal,
    input  logic        cross_valid,
    output logic        norm_en,
    output logic [47:0] norm_vec,
    input  logic [47:0] norm_vec_n,
    input  logic        norm_valid,
    output logic        dot_en,
    output logic [47:0] dot_vec_a,
    output logic [47:0] dot_vec_b,
    input  logic [15:0] dot_scalar,
    input  logic        dot_valid
);

    typedef enum logic [2:0] {
        IDLE, CROSS_ISSUE, CROSS_WAIT, NORM_ISSUE, NORM_WAIT, DOT_ISSUE, DOT_WAIT, FINISH
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [47:0]   ea_q, ea_d, eb_q, eb_d, light_q, light_d;
    logic [47:0]   nvec_q, nvec_d, unit_q, unit_d;
    logic [15:0]   inten_q, inten_d;
    logic          err_q, err_d, degen_q, degen_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          cross_en_q, cross_en_d, norm_en_q, norm_en_d, dot_en_q, dot_en_d;
    logic          cross_zero, timed_out;

    // A normal whose three components are all +/-0 cannot be normalized.
    assign cross_zero = (cross_normal[46:32] == 15'd0) && (cross_normal[30:16] == 15'd0)
                     && (cross_normal[14:0] == 15'd0);
    // Valid gets TIMEOUT+1 WAIT samples, so a timeout lands done TIMEOUT+2 cycles after en.
    assign timed_out  = (cnt_q == CW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        light_d = light_q;
        nvec_d  = nvec_q;
        unit_d  = unit_q;
        inten_d = inten_q;
        err_d   = err_q;
        degen_d = degen_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ea_d    = edge_a;
                    eb_d    = edge_b;
                    light_d = light;
                    state_d = CROSS_ISSUE;
                end
            end
            CROSS_ISSUE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                degen_d = 1'b0;
                state_d = CROSS_WAIT;
            end
            CROSS_WAIT: begin
                if (cross_valid) begin
                    if (cross_zero) begin
                        degen_d = 1'b1;
                        unit_d  = '0;
                        inten_d = '0;
                        state_d = FINISH;
                    end else begin
                        nvec_d  = cross_normal;
                        state_d = NORM_ISSUE;
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NORM_ISSUE: begin
                cnt_d   = '0;
                state_d = NORM_WAIT;
            end
            NORM_WAIT: begin
                if (norm_valid) begin
                    unit_d  = norm_vec_n;
                    state_d = DOT_ISSUE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DOT_ISSUE: begin
                cnt_d   = '0;
                state_d = DOT_WAIT;
            end
            DOT_WAIT: begin
                if (dot_valid) begin
                    // Back-facing (any sign-set value, -0 included) clamps to +0.
                    inten_d = dot_scalar[15] ? 16'h0000 : dot_scalar;
                    state_d = FINISH;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_d     = (state_d != IDLE) && (state_d != FINISH);
    assign done_d     = (state_d == FINISH);
    assign cross_en_d = (state_d == CROSS_ISSUE);
    assign norm_en_d  = (state_d == NORM_ISSUE);
    assign dot_en_d   = (state_d == DOT_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ea_q       <= '0;
            eb_q       <= '0;
            light_q    <= '0;
            nvec_q     <= '0;
            unit_q     <= '0;
            inten_q    <= '0;
            err_q      <= 1'b0;
            degen_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cross_en_q <= 1'b0;
            norm_en_q  <= 1'b0;
            dot_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            light_q    <= light_d;
            nvec_q     <= nvec_d;
            unit_q     <= unit_d;
            inten_q    <= inten_d;
            err_q      <= err_d;
            degen_q    <= degen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cross_en_q <= cross_en_d;
            norm_en_q  <= norm_en_d;
            dot_en_q   <= dot_en_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign intensity   = inten_q;
    assign unit_normal = unit_q;
    assign degenerate  = degen_q;
    assign err         = err_q;
    assign cross_en    = cross_en_q;
    assign cross_vec_a = ea_q;
    assign cross_vec_b = eb_q;
    assign norm_en     = norm_en_q;
    assign norm_vec    = nvec_q;
    assign dot_en      = dot_en_q;
    assign dot_vec_a   = unit_q;
    assign dot_vec_b   = light_q;

endmodule

// File: tb/tb_lambert_shade_seq.sv
// Directed bench for lambert_shade_seq with latency-programmable stub vector units.
module tb_lambert_shade_seq;

    localparam int TO = 8;
    localparam logic [47:0] EA     = 48'hbc00_0000_bc00;
    localparam logic [47:0] EB     = 48'hbc00_0000_0000;
    localparam logic [47:0] EA_DG  = 48'h3c00_0000_3c00;
    localparam logic [47:0] EB_DG  = 48'hbc00_0000_bc00;
    localparam logic [47:0] L_UP   = 48'h0000_3c00_0000;
    localparam logic [47:0] N_UP   = 48'h0000_3c00_0000;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [47:0] edge_a, edge_b, light;
    logic        busy, done, degenerate, err;
    logic [15:0] intensity;
    logic [47:0] unit_normal;
    logic        cross_en, norm_en, dot_en;
    logic [47:0] cross_vec_a, cross_vec_b, norm_vec, dot_vec_a, dot_vec_b;
    logic        cross_valid = 1'b0, norm_valid = 1'b0, dot_valid = 1'b0;
    logic [47:0] cross_normal = '0, norm_vec_n = '0;
    logic [15:0] dot_scalar = '0;

    int          lat_c = 1, lat_n = 1, lat_d = 1;
    logic [47:0] resp_c = '0, resp_n = '0;
    logic [15:0] resp_d = '0;
    int          cnt_c = 0, cnt_n = 0, cnt_d = 0;
    int          n_tests = 0, n_fail = 0;

    int   t_done, t_norm, dc, dn, dd, ddone;
    logic b1, bd;

    logic [47:0] tl_light [5] = '{48'h0000_bc00_0000, 48'h0000_3800_0000, 48'h0000_8000_0000,
                                  48'h0000_3c00_0000, 48'h0000_3c00_0000};
    logic [15:0] td_resp  [5] = '{16'hbc00, 16'h3800, 16'h8000, 16'h7e00, 16'hfe00};
    logic [15:0] td_exp   [5] = '{16'h0000, 16'h3800, 16'h0000, 16'h7e00, 16'h0000};

    always #5 clk = ~clk;

    lambert_shade_seq #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .edge_a(edge_a), .edge_b(edge_b), .light(light),
        .busy(busy), .done(done), .intensity(intensity), .unit_normal(unit_normal),
        .degenerate(degenerate), .err(err),
        .cross_en(cross_en), .cross_vec_a(cross_vec_a), .cross_vec_b(cross_vec_b),
        .cross_normal(cross_normal), .cross_valid(cross_valid),
        .norm_en(norm_en), .norm_vec(norm_vec), .norm_vec_n(norm_vec_n), .norm_valid(norm_valid),
        .dot_en(dot_en), .dot_vec_a(dot_vec_a), .dot_vec_b(dot_vec_b),
        .dot_scalar(dot_scalar), .dot_valid(dot_valid)
    );

    // Stub units: valid pulses lat cycles after the en edge; lat=0 means never.
    always @(posedge clk) begin
        cross_normal <= resp_c;
        if (cross_en) begin
            cross_valid <= (lat_c == 1);
            cnt_c       <= (lat_c > 1) ? lat_c - 1 : 0;
        end else begin
            cross_valid <= (cnt_c == 1);
            cnt_c       <= (cnt_c > 0) ? cnt_c - 1 : 0;
        end
    end

    always @(posedge clk) begin
        norm_vec_n <= resp_n;
        if (norm_en) begin
            norm_valid <= (lat_n == 1);
            cnt_n      <= (lat_n > 1) ? lat_n - 1 : 0;
        end else begin
            norm_valid <= (cnt_n == 1);
            cnt_n      <= (cnt_n > 0) ? cnt_n - 1 : 0;
        end
    end

    always @(posedge clk) begin
        dot_scalar <= resp_d;
        if (dot_en) begin
            dot_valid <= (lat_d == 1);
            cnt_d     <= (lat_d > 1) ? lat_d - 1 : 0;
        end else begin
            dot_valid <= (cnt_d == 1);
            cnt_d     <= (cnt_d > 0) ? cnt_d - 1 : 0;
        end
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 48'({busy, done, err, degenerate, cross_en, norm_en, dot_en}), 48'h0);
        chk({tag, "_int"}, 48'(intensity), 48'h0);
        chk({tag, "_normal"}, unit_normal, 48'h0);
        chk({tag, "_cva"}, cross_vec_a, 48'h0);
        chk({tag, "_cvb"}, cross_vec_b, 48'h0);
        chk({tag, "_nv"}, norm_vec, 48'h0);
        chk({tag, "_dva"}, dot_vec_a, 48'h0);
        chk({tag, "_dvb"}, dot_vec_b, 48'h0);
    endtask

    // One transaction from a negedge; also checks en operands and bus stability until valid.
    task automatic run_op(input logic [47:0] ea, input logic [47:0] eb, input logic [47:0] lt,
                          input bit poke, output int o_done, output int o_norm,
                          output int o_c, output int o_n, output int o_d, output int o_dn,
                          output logic o_b1, output logic o_bd);
        logic [47:0] hca, hcb, hn, hda, hdb;
        bit pc, pn, pd;
        pc = 0; pn = 0; pd = 0;
        hca = '0; hcb = '0; hn = '0; hda = '0; hdb = '0;
        o_done = -1; o_norm = -1; o_c = 0; o_n = 0; o_d = 0; o_dn = 0; o_b1 = 1'b0; o_bd = 1'b1;
        edge_a = ea; edge_b = eb; light = lt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc == 1) o_b1 = busy;
            if (poke && cyc == 2) begin
                start = 1'b1; edge_a = ~ea; edge_b = ~eb; light = ~lt;
            end else if (poke && cyc == 3) begin
                start = 1'b0; edge_a = ea; edge_b = eb; light = lt;
            end
            if (cross_en) begin
                o_c++; pc = 1; hca = cross_vec_a; hcb = cross_vec_b;
                chk("cross_vec_a", cross_vec_a, ea);
                chk("cross_vec_b", cross_vec_b, eb);
            end else if (pc) begin
                chk("cross_a_stable", cross_vec_a, hca);
                chk("cross_b_stable", cross_vec_b, hcb);
                if (cross_valid) pc = 0;
            end
            if (norm_en) begin
                o_n++; pn = 1; hn = norm_vec; o_norm = cyc;
                chk("norm_vec", norm_vec, resp_c);
            end else if (pn) begin
                chk("norm_stable", norm_vec, hn);
                if (norm_valid) pn = 0;
            end
            if (dot_en) begin
                o_d++; pd = 1; hda = dot_vec_a; hdb = dot_vec_b;
                chk("dot_vec_a", dot_vec_a, resp_n);
                chk("dot_vec_b", dot_vec_b, lt);
            end else if (pd) begin
                chk("dot_a_stable", dot_vec_a, hda);
                chk("dot_b_stable", dot_vec_b, hdb);
                if (dot_valid) pd = 0;
            end
            if (done) begin
                o_dn++;
                if (o_done < 0) begin
                    o_done = cyc;
                    o_bd   = busy;
                end
            end
            if (o_done >= 0 && cyc >= o_done + 2) break;
            @(negedge clk);
        end
        if (o_done < 0) chk("done_within_budget", 48'h0, 48'h1);
        $display("[TB] op ea=%h eb=%h light=%h done@%0d intensity=%h normal=%h err=%b degen=%b",
                 ea, eb, lt, o_done, intensity, unit_normal, err, degenerate);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0;
        edge_a = '0; edge_b = '0; light = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal: normal (0,1,0), light (0,1,0) -> 1.0
        lat_c = 1; lat_n = 1; lat_d = 1;
        resp_c = N_UP; resp_n = N_UP; resp_d = 16'h3c00;
        run_op(EA, EB, L_UP, 1'b0, t_done, t_norm, dc, dn, dd, ddone, b1, bd);
        chk("nom_normal", unit_normal, N_UP);
        chk("nom_int", 48'(intensity), 48'h3c00);
        chk("nom_err_degen", 48'({err, degenerate}), 48'h0);
        chk("nom_en_counts", 48'({8'(dc), 8'(dn), 8'(dd)}), 48'h01_01_01);
        chk("nom_done_count", 48'(ddone), 48'd1);
        chk("nom_latency", 48'(t_done), 48'd7);
        chk("nom_busy_first", 48'(b1), 48'd1);
        chk("nom_busy_at_done", 48'(bd), 48'd0);

        // Clamp table with varied unit latencies
        for (int i = 0; i < 5; i++) begin
            lat_c = 1 + (i % 2); lat_n = 1 + i; lat_d = 2;
            resp_d = td_resp[i];
            run_op(EA, EB, tl_light[i], 1'b0, t_done, t_norm, dc, dn, dd, ddone, b1, bd);
            chk("clamp_int", 48'(intensity), 48'(td_exp[i]));
            chk("clamp_latency", 48'(t_done), 48'(3 + lat_c + lat_n + lat_d + 1));
            chk("clamp_done_count", 48'(ddone), 48'd1);
        end

        // Degenerate: cross result is -0,+0,+0
        lat_c = 1; lat_n = 1; lat_d = 1;
        resp_c = 48'h8000_0000_0000;
        run_op(EA_DG, EB_DG, L_UP, 1'b0, t_done, t_norm, dc, dn, dd, ddone, b1, bd);
        chk("degen_flag", 48'(degenerate), 48'd1);
        chk("degen_int", 48'(intensity), 48'h0);
        chk("degen_normal", unit_normal, 48'h0);
        chk("degen_no_norm_dot", 48'({8'(dn), 8'(dd)}), 48'h0);
        chk("degen_err", 48'(err), 48'd0);
        chk("degen_done_count", 48'(ddone), 48'd1);

        // Smallest nonzero component is not degenerate
        resp_c = 48'h0000_0001_0000; resp_n = N_UP; resp_d = 16'h3c00;
        run_op(EA, EB, L_UP, 1'b0, t_done, t_norm, dc, dn, dd, ddone, b1, bd);
        chk("tiny_not_degen", 48'(degenerate), 48'd0);
        chk("tiny_int", 48'(intensity), 48'h3c00);

        // Timeout in normalize
        resp_c = N_UP; lat_n = 0;
        run_op(EA, EB, L_UP, 1'b0, t_done, t_norm, dc, dn, dd, ddone, b1, bd);
        chk("to_err", 48'(err), 48'd1);
        chk("to_delay", 48'(t_done - t_norm), 48'(TO + 2));
        chk("to_no_dot", 48'(dd), 48'd0);
        chk("to_done_count", 48'(ddone), 48'd1);
        chk("to_degen", 48'(degenerate), 48'd0);

        // Next start clears err
        lat_n = 1;
        run_op(EA, EB, L_UP, 1'b0, t_done, t_norm, dc, dn, dd, ddone, b1, bd);
        chk("after_to_err", 48'(err), 48'd0);
        chk("after_to_int", 48'(intensity), 48'h3c00);

        // start re-asserted while busy is ignored
        lat_c = 2; lat_n = 2; lat_d = 2;
        run_op(EA, EB, L_UP, 1'b1, t_done, t_norm, dc, dn, dd, ddone, b1, bd);
        chk("poke_en_counts", 48'({8'(dc), 8'(dn), 8'(dd)}), 48'h01_01_01);
        chk("poke_done_count", 48'(ddone), 48'd1);
        chk("poke_latency", 48'(t_done), 48'd10);
        chk("poke_normal", unit_normal, N_UP);
        chk("poke_idle_after", 48'(busy), 48'd0);

        // Asynchronous reset during NORM_WAIT
        lat_c = 1; lat_n = 3; lat_d = 1;
        edge_a = EA; edge_b = EB; light = L_UP; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_norm_en", 48'(norm_en), 48'd1);
        @(negedge clk);
        chk("pre_rst_busy", 48'(busy), 48'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_en", 48'({cross_en, norm_en, dot_en}), 48'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_idle", 48'({busy, done}), 48'h0);
        lat_n = 1;
        run_op(EA, EB, L_UP, 1'b0, t_done, t_norm, dc, dn, dd, ddone, b1, bd);
        chk("post_rst_normal", unit_normal, N_UP);
        chk("post_rst_int", 48'(intensity), 48'h3c00);
        chk("post_rst_latency", 48'(t_done), 48'd7);
        chk("post_rst_flags", 48'({err, degenerate}), 48'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
